death_sequence_ctrl: RTL

- Game-state sequencer that drives the layer-control inputs of the VGA object mux when the player is hit.
- Runs freeze → smiley blink → death-overlay fade-in → wait for keypress → restart pulse.
- Counts frames using the VGA start-of-frame strobe.
- Its outputs gate the smiley drawing request, enable the death-foreground layer, supply a fade level to the death-foreground bitmap, and freeze/restart game logic.

---
 rtl/death_sequence_ctrl_if.sv | 23 ++
 rtl/death_sequence_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/death_sequence_ctrl_if.sv
// Signal bundle between the death-sequence controller and the game/VGA side.
// The slave side is the controller; the master side drives frame, hit and key inputs.
interface death_sequence_ctrl_if;
    logic       startOfFrame;
    logic       playerHit;
    logic       anyKey;
    logic       smileyShow;
    logic       deathShow;
    logic [2:0] fadeLevel;
    logic       gameFreeze;
    logic       restartPulse;
    logic [2:0] seqState;

    modport master (
        output startOfFrame, playerHit, anyKey,
        input  smileyShow, deathShow, fadeLevel, gameFreeze, restartPulse, seqState
    );

    modport slave (
        input  startOfFrame, playerHit, anyKey,
        output smileyShow, deathShow, fadeLevel, gameFreeze, restartPulse, seqState
    );
endinterface

// File: rtl/death_sequence_ctrl.sv
// Player-death sequencer: freeze, smiley blink, overlay fade-in, wait for key, restart strobe.
// Optional macro DEATH_SEQ_TIMEOUT_EN adds an auto-restart after TIMEOUT_FRAMES in WAIT_KEY.
module death_sequence_ctrl #(
    parameter int FREEZE_FRAMES  = 30,
    parameter int BLINK_PERIOD   = 8,
    parameter int BLINK_COUNT    = 6,
    parameter int FADE_STEP      = 4,
    parameter int TIMEOUT_FRAMES = 600
) (
    input logic                   clk,
    input logic                   reset,
    death_sequence_ctrl_if.slave  bus
);

    localparam logic [2:0] S_PLAY     = 3'd0;
    localparam logic [2:0] S_FREEZE   = 3'd1;
    localparam logic [2:0] S_BLINK    = 3'd2;
    localparam logic [2:0] S_FADE     = 3'd3;
    localparam logic [2:0] S_WAIT_KEY = 3'd4;
    localparam logic [2:0] S_RESTART  = 3'd5;

    localparam int MAX_A = (FREEZE_FRAMES > BLINK_PERIOD) ? FREEZE_FRAMES : BLINK_PERIOD;
    localparam int MAX_B = (MAX_A > FADE_STEP) ? MAX_A : FADE_STEP;
`ifdef DEATH_SEQ_TIMEOUT_EN
    localparam int MAX_F = (MAX_B > TIMEOUT_FRAMES) ? MAX_B : TIMEOUT_FRAMES;
`else
    localparam int MAX_F = MAX_B;
`endif
    localparam int CNT_W = $clog2(MAX_F + 1) + 1;
    localparam int TGL_W = $clog2(BLINK_COUNT + 1) + 1;

    localparam logic [CNT_W-1:0] FREEZE_LIM = CNT_W'(FREEZE_FRAMES);
    localparam logic [CNT_W-1:0] PERIOD_LIM = CNT_W'(BLINK_PERIOD);
    localparam logic [CNT_W-1:0] STEP_LIM   = CNT_W'(FADE_STEP);
    localparam logic [TGL_W-1:0] TGL_LIM    = TGL_W'(BLINK_COUNT);
`ifdef DEATH_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TIMEOUT_FRAMES);
`endif

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] frame_q,   frame_d;
    logic [TGL_W-1:0] tgl_q,     tgl_d;
    logic             smiley_q,  smiley_d;
    logic [2:0]       fade_q,    fade_d;
    logic             armed_q,   armed_d;
    logic             death_q;
    logic             freeze_q;
    logic             restart_q;
    logic [CNT_W-1:0] frame_inc;

    assign frame_inc = frame_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        tgl_d    = tgl_q;
        smiley_d = smiley_q;
        fade_d   = fade_q;
        armed_d  = armed_q;

        case (state_q)
            S_PLAY: begin
                // A start-of-frame coinciding with the hit is deliberately not counted.
                smiley_d = 1'b1;
                fade_d   = 3'd0;
                if (bus.playerHit) begin
                    state_d = S_FREEZE;
                    frame_d = '0;
                end
            end
            S_FREEZE: begin
                if (bus.startOfFrame) begin
                    if (frame_q >= FREEZE_LIM) begin
                        state_d = S_BLINK;
                        frame_d = '0;
                        tgl_d   = '0;
                    end else begin
                        frame_d = frame_inc;
                    end
                end
            end
            S_BLINK: begin
                if (bus.startOfFrame) begin
                    if (tgl_q >= TGL_LIM) begin
                        state_d  = S_FADE;
                        smiley_d = 1'b0;
                        frame_d  = '0;
                        fade_d   = 3'd0;
                    end else if (frame_inc >= PERIOD_LIM) begin
                        frame_d  = '0;
                        smiley_d = ~smiley_q;
                        tgl_d    = tgl_q + TGL_W'(1);
                    end else begin
                        frame_d  = frame_inc;
                    end
                end
            end
            S_FADE: begin
                if (bus.startOfFrame) begin
                    if (frame_inc >= STEP_LIM) begin
                        frame_d = '0;
                        if (fade_q == 3'd7) begin
                            state_d = S_WAIT_KEY;
                            armed_d = 1'b0;
                        end else begin
                            fade_d = fade_q + 3'd1;
                        end
                    end else begin
                        frame_d = frame_inc;
                    end
                end
            end
            S_WAIT_KEY: begin
                // Arming on a sampled release keeps a key held since the hit from restarting.
                fade_d  = 3'd7;
                armed_d = armed_q | ~bus.anyKey;
                if (bus.anyKey && armed_q) begin
                    state_d = S_RESTART;
                end
`ifdef DEATH_SEQ_TIMEOUT_EN
                else if (bus.startOfFrame) begin
                    if (frame_inc >= TMO_LIM) begin
                        state_d = S_RESTART;
                    end else begin
                        frame_d = frame_inc;
                    end
                end
`endif
            end
            S_RESTART: begin
                state_d  = S_PLAY;
                armed_d  = 1'b0;
                smiley_d = 1'b1;
                fade_d   = 3'd0;
            end
            default: begin
                state_d  = S_PLAY;
                smiley_d = 1'b1;
                fade_d   = 3'd0;
                armed_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_PLAY;
            frame_q   <= '0;
            tgl_q     <= '0;
            smiley_q  <= 1'b1;
            fade_q    <= 3'd0;
            armed_q   <= 1'b0;
            death_q   <= 1'b0;
            freeze_q  <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            tgl_q     <= tgl_d;
            smiley_q  <= smiley_d;
            fade_q    <= fade_d;
            armed_q   <= armed_d;
            death_q   <= (state_d == S_FADE) || (state_d == S_WAIT_KEY);
            freeze_q  <= (state_d != S_PLAY);
            restart_q <= (state_d == S_RESTART);
        end
    end

    assign bus.smileyShow   = smiley_q;
    assign bus.deathShow    = death_q;
    assign bus.fadeLevel    = fade_q;
    assign bus.gameFreeze   = freeze_q;
    assign bus.restartPulse = restart_q;
    assign bus.seqState     = state_q;

endmodule
